// File: rtl/otter_pkg.sv
// Shared fetch-stage types and constants for the OTTER core.
package otter_pkg;

    localparam int unsigned ILEN = 32;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Small circular prefetch queue of {pc, ir} entries with flush.
module otter_fetch_fifo
    import otter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            wdata,
    output fetch_entry_t            rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // The issue credit logic upstream must never let the queue overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch: owns the fetch PC, issues reads to the instruction
// port, queues responses and hands them to decode over valid/ready.
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    output logic        IF_VALID,
    output logic [31:0] IF_IR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC_INC,
    input  logic        DE_READY
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic          epoch;
    logic          tag_epoch;
    logic [31:0]   tag_pc;
    logic          issue;
    logic          pop;
    logic          push;
    logic [SW-1:0] credit;
    logic          empty;
    logic          full_unused;
    logic [CW-1:0] count;
    logic [1:0]    redirect_pc_unused;
    fetch_entry_t  head;
    fetch_entry_t  resp;

    assign redirect_pc_unused = REDIRECT_PC[1:0];

    // Queue slots already spoken for, counting the read still in flight.
    assign pop    = IF_VALID && DE_READY;
    assign credit = SW'(count) + SW'(inflight) - SW'(pop);
    assign issue  = RESET_N && !REDIRECT && (credit < SW'(DEPTH));

    assign MEM_RDEN1 = issue;
    assign MEM_ADDR1 = fetch_pc[15:2];

    // Responses tagged with an older epoch belong to a flushed stream.
    assign push    = inflight && (tag_epoch == epoch) && !REDIRECT;
    assign resp.pc = tag_pc;
    assign resp.ir = MEM_DOUT1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc  <= RESET_VEC;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            tag_epoch <= 1'b0;
            tag_pc    <= '0;
        end else begin
            inflight <= issue;
            if (REDIRECT) begin
                fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue) begin
                tag_pc    <= fetch_pc;
                tag_epoch <= epoch;
            end
        end
    end

    otter_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (REDIRECT),
        .wdata (resp),
        .rdata (head),
        .full  (full_unused),
        .empty (empty),
        .count (count)
    );

    // Head fields read as zero whenever nothing valid is presented.
    assign IF_VALID  = !empty;
    assign IF_IR     = IF_VALID ? head.ir : '0;
    assign IF_PC     = IF_VALID ? head.pc : '0;
    assign IF_PC_INC = IF_VALID ? (head.pc + 32'd4) : '0;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: directed vector tables, reset checks and a
// randomized run against a queue-based reference model.
module tb_otter_fetch_unit;

    localparam int DEPTH = 2;

    logic        CLK;
    logic        RESET_N;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        MEM_RDEN1;
    logic [13:0] MEM_ADDR1;
    logic [31:0] MEM_DOUT1;
    logic        IF_VALID;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_INC;
    logic        DE_READY;

    otter_fetch_unit #(
        .RESET_VEC (32'h0000_0000),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .MEM_RDEN1   (MEM_RDEN1),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_DOUT1   (MEM_DOUT1),
        .IF_VALID    (IF_VALID),
        .IF_IR       (IF_IR),
        .IF_PC       (IF_PC),
        .IF_PC_INC   (IF_PC_INC),
        .DE_READY    (DE_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rden;
        logic [13:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: queue contents, one pending read, fetch PC, stream generation.
    ent_t        mq[$];
    logic [31:0] m_fpc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int          m_gen;
    int          m_pend_gen;

    function automatic logic [31:0] word_of(input logic [13:0] a);
        return {2'b00, a, a, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = 32'h0000_0000;
        m_pend = 1'b0;
        m_gen  = 0;
    endtask

    // One clock cycle: drive, check at the falling edge, then advance model and memory.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                        input bit use_vec, input vec_t v);
        bit          m_valid;
        bit          m_pop;
        bit          m_rden;
        int          credit;
        logic        rd_q;
        logic [13:0] addr_q;
        ent_t        e;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        DE_READY    = rdy;
        @(negedge CLK);
        m_valid = mq.size() > 0;
        m_pop   = m_valid && rdy;
        credit  = mq.size() + int'(m_pend) - int'(m_pop);
        m_rden  = !redir && credit < DEPTH;
        chk("rden", 32'(MEM_RDEN1), 32'(m_rden));
        chk("addr", 32'(MEM_ADDR1), 32'(m_fpc[15:2]));
        chk("valid", 32'(IF_VALID), 32'(m_valid));
        if (m_valid) begin
            chk("if_pc", IF_PC, mq[0].pc);
            chk("if_ir", IF_IR, mq[0].ir);
            chk("if_pc_inc", IF_PC_INC, mq[0].pc + 32'd4);
        end
        if (use_vec) begin
            chk("vec_rden", 32'(MEM_RDEN1), 32'(v.e_rden));
            chk("vec_addr", 32'(MEM_ADDR1), 32'(v.e_addr));
            chk("vec_valid", 32'(IF_VALID), 32'(v.e_valid));
            if (v.e_valid) begin
                chk("vec_pc", IF_PC, v.e_pc);
                chk("vec_ir", IF_IR, word_of(v.e_pc[15:2]));
                chk("vec_pc_inc", IF_PC_INC, v.e_pc + 32'd4);
            end
        end
        rd_q   = MEM_RDEN1;
        addr_q = MEM_ADDR1;
        @(posedge CLK);
        if (m_pop) void'(mq.pop_front());
        if (m_pend && m_pend_gen == m_gen && !redir) begin
            e.pc = m_pend_pc;
            e.ir = word_of(m_pend_pc[15:2]);
            mq.push_back(e);
        end
        chk("model_depth", 32'(mq.size() <= DEPTH), 32'd1);
        if (redir) begin
            mq.delete();
            m_gen++;
            m_fpc  = {rpc[31:2], 2'b00};
            m_pend = 1'b0;
        end else begin
            m_pend = m_rden;
            if (m_rden) begin
                m_pend_pc  = m_fpc;
                m_pend_gen = m_gen;
                m_fpc      = m_fpc + 32'd4;
            end
        end
        #1;
        MEM_DOUT1 = rd_q ? word_of(addr_q) : 32'hDEAD_BEEF;
    endtask

    // Asynchronous reset pulse: outputs must clear without waiting for a clock edge.
    task automatic reset_pulse();
        RESET_N = 1'b0;
        #1;
        chk("rst_valid", 32'(IF_VALID), 32'd0);
        chk("rst_rden", 32'(MEM_RDEN1), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR1), 32'd0);
        chk("rst_pc", IF_PC, 32'd0);
        chk("rst_ir", IF_IR, 32'd0);
        chk("rst_pc_inc", IF_PC_INC, 32'd0);
        model_reset();
        MEM_DOUT1 = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    vec_t vecs[$];
    vec_t vrst[$];
    vec_t none;

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                                input logic e_rden, input logic [13:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_rden = e_rden; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        none = mk(0, 0, 0, 0, 0, 0, 0);
        // Startup stream, 5-cycle stall, redirect with a read in flight,
        // back-to-back redirects and the 32-bit PC wrap.
        vecs.push_back(mk(0, 0, 1, 1, 14'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0001, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0002, 1, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0003, 1, 32'h0000_0004));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 14'h0004, 1, 32'h0000_0008));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0004, 1, 32'h0000_0008));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0005, 1, 32'h0000_000C));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0006, 1, 32'h0000_0010));
        vecs.push_back(mk(1, 32'h0000_0107, 1, 0, 14'h0007, 1, 32'h0000_0014));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0041, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0042, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0043, 1, 32'h0000_0104));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0044, 1, 32'h0000_0108));
        vecs.push_back(mk(1, 32'h0000_0200, 1, 0, 14'h0045, 1, 32'h0000_010C));
        vecs.push_back(mk(1, 32'h0000_0300, 1, 0, 14'h0080, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h00C0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h00C1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h00C2, 1, 32'h0000_0300));
        vecs.push_back(mk(0, 0, 1, 1, 14'h00C3, 1, 32'h0000_0304));
        vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 0, 14'h00C4, 1, 32'h0000_0308));
        vecs.push_back(mk(0, 0, 1, 1, 14'h3FFE, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h3FFF, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0000, 1, 32'hFFFF_FFF8));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0001, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 1, 1, 14'h0002, 1, 32'h0000_0000));

        vrst.push_back(mk(0, 0, 1, 1, 14'h0000, 0, 0));
        vrst.push_back(mk(0, 0, 1, 1, 14'h0001, 0, 0));
        vrst.push_back(mk(0, 0, 1, 1, 14'h0002, 1, 32'h0000_0000));
        vrst.push_back(mk(0, 0, 1, 1, 14'h0003, 1, 32'h0000_0004));

        RESET_N     = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        DE_READY    = 1'b0;
        MEM_DOUT1   = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        reset_pulse();

        foreach (vecs[i]) step(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, 1'b1, vecs[i]);

        // Fill the queue with decode stalled, then reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, none);
        chk("full_before_reset", 32'(IF_VALID), 32'd1);
        reset_pulse();
        foreach (vrst[i]) step(vrst[i].redir, vrst[i].rpc, vrst[i].rdy, 1'b1, vrst[i]);

        for (int i = 0; i < 800; i++) begin
            logic        r;
            logic [31:0] t;
            logic        d;
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                r = ($urandom_range(0, 9) == 0);
                t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom();
                d = ($urandom_range(0, 3) != 0);
                step(r, t, d, 1'b0, none);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
